// File: rtl/mips_pkg.sv
// Shared fetch-side types: error codes, fetch FSM states, default instruction size.
package mips_pkg;

  localparam int DEF_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } fetch_err_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_RESP
  } fetch_state_t;

endpackage

// File: rtl/byte_ram.sv
// DEPTH x 8 byte store: one synchronous write port, INSTR_BYTES combinational read taps.
module byte_ram
  import mips_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    DEPTH       = 1024,
  parameter int    INSTR_BYTES = DEF_INSTR_BYTES,
  parameter string INIT_FILE   = ""
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [7:0]                  wdata,
  input  logic [ADDR_W-1:0]           raddr,
  output logic [INSTR_BYTES-1:0][7:0] rdata
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  // Load port: writes beyond DEPTH are dropped. No reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_X)) mem[waddr[IDX_W-1:0]] <= wdata;
  end

  // Read taps at raddr+k; taps past the end read as zero instead of X.
  for (genvar k = 0; k < INSTR_BYTES; k++) begin : g_tap
    logic [ADDR_W:0] a;
    assign a        = {1'b0, raddr} + (ADDR_W+1)'(k);
    assign rdata[k] = (a < DEPTH_X) ? mem[a[IDX_W-1:0]] : 8'h00;
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: valid/ready request, LATENCY-cycle read, held response,
// flush, fault reporting and a byte load port.
module instr_fetch_mem
  import mips_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    DEPTH       = 1024,
  parameter int    INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int    LATENCY     = 1,
  parameter int    BIG_ENDIAN  = 1,
  parameter int    ALIGN_CHECK = 1,
  parameter string INIT_FILE   = "instruct_mem.txt"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [8*INSTR_BYTES-1:0] resp_instr,
  output logic [1:0]               resp_err,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [7:0]               ld_data,
  output logic                     busy
);

  localparam int              IW      = 8*INSTR_BYTES;
  localparam int              CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(INSTR_BYTES - 1);

  fetch_state_t               state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [ADDR_W-1:0]          pc_q, pc_nxt;
  logic [IW-1:0]              instr_q, instr_nxt, asm_instr;
  fetch_err_t                 err_q, err_nxt, fault;
  logic [INSTR_BYTES-1:0][7:0] taps;
  logic                       misalign, out_of_range;

  byte_ram #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INSTR_BYTES(INSTR_BYTES), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk(clk), .we(ld_en), .waddr(ld_addr), .wdata(ld_data), .raddr(pc_q), .rdata(taps)
  );

  // Faults on the captured pc; range check one bit wider so pc near the top cannot wrap.
  always_comb begin
    misalign     = (ALIGN_CHECK != 0) && ((pc_q % ADDR_W'(INSTR_BYTES)) != '0);
    out_of_range = (({1'b0, pc_q} + LAST_X) >= DEPTH_X);
    fault        = misalign ? ERR_MISALIGN : (out_of_range ? ERR_RANGE : ERR_OK);
  end

  // Byte k of the fetch lands at the top (big endian) or bottom (little endian).
  always_comb begin
    asm_instr = '0;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      if (BIG_ENDIAN != 0) asm_instr[IW-1-8*k -: 8] = taps[k];
      else                 asm_instr[8*k +: 8]      = taps[k];
    end
  end

  // State and response registers; async reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pc_q    <= pc_nxt;
      instr_q <= instr_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next state: accept in IDLE, count down in READ, hold in RESP; flush wins outside IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc_q;
    instr_nxt = instr_q;
    err_nxt   = err_q;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          pc_nxt    = req_pc;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (flush) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          instr_nxt = '0;
          err_nxt   = ERR_OK;
        end else if (cnt == '0) begin
          err_nxt   = fault;
          instr_nxt = (fault == ERR_OK) ? asm_instr : '0;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (flush) begin
          state_nxt = S_IDLE;
          instr_nxt = '0;
          err_nxt   = ERR_OK;
        end else if (resp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_instr = instr_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Two instances: u_a (LATENCY=1, big endian, align check) and
// u_b (LATENCY=3, little endian, no align check), checked against a byte-array model.
module tb_instr_fetch_mem;

  localparam int AW  = 10;
  localparam int DEP = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic            req_valid [2];
  logic            req_ready [2];
  logic [AW-1:0]   req_pc    [2];
  logic            resp_valid[2];
  logic            resp_ready[2];
  logic [31:0]     resp_instr[2];
  logic [1:0]      resp_err  [2];
  logic            flush     [2];
  logic            ld_en     [2];
  logic [AW-1:0]   ld_addr   [2];
  logic [7:0]      ld_data   [2];
  logic            busy      [2];

  logic [7:0] mdl [2][DEP];
  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .ADDR_W(AW), .DEPTH(DEP), .INSTR_BYTES(4), .LATENCY(1),
    .BIG_ENDIAN(1), .ALIGN_CHECK(1), .INIT_FILE("")
  ) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_pc(req_pc[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_instr(resp_instr[0]), .resp_err(resp_err[0]), .flush(flush[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .busy(busy[0])
  );

  instr_fetch_mem #(
    .ADDR_W(AW), .DEPTH(DEP), .INSTR_BYTES(4), .LATENCY(3),
    .BIG_ENDIAN(0), .ALIGN_CHECK(0), .INIT_FILE("")
  ) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_pc(req_pc[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_instr(resp_instr[1]), .resp_err(resp_err[1]), .flush(flush[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .busy(busy[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Expected response from the byte model: misalign beats range, any fault gives zero data.
  function automatic void model(input int d, input int pc,
                                output logic [1:0] err, output logic [31:0] ins);
    ins = '0;
    err = 2'b00;
    if (d == 0 && (pc % 4) != 0) err = 2'b01;
    else if (pc + 3 >= DEP)      err = 2'b10;
    else
      for (int k = 0; k < 4; k++)
        ins = ins | (32'(mdl[d][pc+k]) << ((d == 0) ? 8*(3-k) : 8*k));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int d, input string tag);
    check({tag, ".req_ready"},  64'(req_ready[d]),  64'd1);
    check({tag, ".resp_valid"}, 64'(resp_valid[d]), 64'd0);
    check({tag, ".busy"},       64'(busy[d]),       64'd0);
  endtask

  task automatic load(input int d, input int addr, input logic [7:0] data);
    ld_en[d] = 1'b1; ld_addr[d] = AW'(addr); ld_data[d] = data;
    step();
    ld_en[d] = 1'b0;
    mdl[d][addr] = data;
  endtask

  // One full transaction: request, latency, hold under back-pressure, handshake.
  // Request is driven after edge N and sampled at N+1, so resp_valid is seen after N+LATENCY+1.
  task automatic fetch(input int d, input int pc, input int hold, input bit fl);
    logic [1:0]  e_err;
    logic [31:0] e_ins;
    int n;
    string t;
    t = $sformatf("u%0d.pc%0d", d, pc);
    model(d, pc, e_err, e_ins);
    req_valid[d] = 1'b1; req_pc[d] = AW'(pc); flush[d] = fl;
    resp_ready[d] = (hold == 0);
    check({t, ".req_ready"}, 64'(req_ready[d]), 64'd1);
    step();
    req_valid[d] = 1'b0; flush[d] = 1'b0;
    check({t, ".busy"}, 64'(busy[d]), 64'd1);
    n = 0;
    while (resp_valid[d] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({t, ".latency"}, 64'(n), 64'(lat(d)));
    check({t, ".instr"}, 64'(resp_instr[d]), 64'(e_ins));
    check({t, ".err"},   64'(resp_err[d]),   64'(e_err));
    for (int i = 0; i < hold; i++) begin
      step();
      check({t, ".hold_valid"}, 64'(resp_valid[d]), 64'd1);
      check({t, ".hold_instr"}, 64'(resp_instr[d]), 64'(e_ins));
      check({t, ".hold_ready"}, 64'(req_ready[d]),  64'd0);
    end
    resp_ready[d] = 1'b1;
    step();
    resp_ready[d] = 1'b0;
    chk_idle(d, {t, ".done"});
  endtask

  initial begin
    logic [1:0]  e_err;
    logic [31:0] e_ins;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_pc[d] = '0; resp_ready[d] = 0; flush[d] = 0;
      ld_en[d] = 0; ld_addr[d] = '0; ld_data[d] = '0;
    end

    // Reset values while rst is held low
    #12;
    for (int d = 0; d < 2; d++) begin
      chk_idle(d, $sformatf("u%0d.rst", d));
      check($sformatf("u%0d.rst.instr", d), 64'(resp_instr[d]), 64'd0);
      check($sformatf("u%0d.rst.err", d),   64'(resp_err[d]),   64'd0);
    end
    rst = 1'b1;
    step();

    // Fill both memories with random bytes so the model knows every location
    for (int i = 0; i < DEP; i++) begin
      for (int d = 0; d < 2; d++) begin
        ld_en[d] = 1'b1; ld_addr[d] = AW'(i); ld_data[d] = 8'($urandom);
        mdl[d][i] = ld_data[d];
      end
      step();
    end
    ld_en[0] = 1'b0; ld_en[1] = 1'b0;

    // Directed: known word at 0 in both byte orders
    for (int d = 0; d < 2; d++) begin
      load(d, 0, 8'h20); load(d, 1, 8'h08); load(d, 2, 8'h00); load(d, 3, 8'h05);
    end
    fetch(0, 0, 0, 0);
    check("u0.word0.const", 64'(resp_instr[0]), 64'h2008_0005);
    fetch(1, 0, 0, 0);
    check("u1.word0.const", 64'(resp_instr[1]), 64'h0500_0820);

    // Fault boundaries
    fetch(0, 2, 0, 0);
    fetch(0, 1022, 0, 0);
    fetch(0, 1020, 0, 0);
    fetch(1, 1022, 0, 0);
    fetch(1, 1021, 0, 0);
    fetch(1, 1020, 0, 0);
    fetch(1, 3, 0, 0);

    // Back-pressure: hold 5 cycles with LATENCY=3
    fetch(1, 16, 5, 0);

    // Flush together with a request in IDLE: request still accepted
    fetch(0, 8, 0, 1);

    // Flush during READ: no response, idle next cycle, next request fine
    req_valid[1] = 1'b1; req_pc[1] = AW'(8);
    step();
    req_valid[1] = 1'b0;
    step();
    flush[1] = 1'b1;
    step();
    flush[1] = 1'b0;
    chk_idle(1, "u1.flush_read");
    check("u1.flush_read.instr", 64'(resp_instr[1]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("u1.flush_read.novalid", 64'(resp_valid[1]), 64'd0);
    end
    fetch(1, 4, 0, 0);

    // Flush during RESP: outputs clear
    req_valid[0] = 1'b1; req_pc[0] = AW'(4);
    step();
    req_valid[0] = 1'b0;
    step();
    check("u0.flush_resp.valid_before", 64'(resp_valid[0]), 64'd1);
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    chk_idle(0, "u0.flush_resp");
    check("u0.flush_resp.instr", 64'(resp_instr[0]), 64'd0);
    check("u0.flush_resp.err",   64'(resp_err[0]),   64'd0);

    // Load during READ is visible; load after RESP entry is not
    req_valid[1] = 1'b1; req_pc[1] = AW'(4);
    step();
    req_valid[1] = 1'b0;
    ld_en[1] = 1'b1; ld_addr[1] = AW'(5); ld_data[1] = 8'hFF;
    mdl[1][5] = 8'hFF;
    step();
    ld_en[1] = 1'b0;
    model(1, 4, e_err, e_ins);
    step();
    step();
    check("u1.ld_read.valid", 64'(resp_valid[1]), 64'd1);
    check("u1.ld_read.byte1", 64'(resp_instr[1][15:8]), 64'hFF);
    check("u1.ld_read.instr", 64'(resp_instr[1]), 64'(e_ins));
    load(1, 5, 8'h3C);
    check("u1.ld_resp.held", 64'(resp_instr[1]), 64'(e_ins));
    resp_ready[1] = 1'b1;
    step();
    resp_ready[1] = 1'b0;
    chk_idle(1, "u1.ld_resp.done");
    fetch(1, 4, 0, 0);

    // Random fetches interleaved with random loads
    for (int it = 0; it < 60; it++) begin
      int d, pc;
      d = int'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0)
        load(d, int'($urandom_range(DEP-1, 0)), 8'($urandom));
      if ($urandom_range(3, 0) != 0) pc = 4 * int'($urandom_range(DEP/4 - 1, 0));
      else                           pc = int'($urandom_range(DEP-1, 0));
      fetch(d, pc, int'($urandom_range(2, 0)), 1'b0);
    end

    // Asynchronous reset mid-READ, memory preserved
    req_valid[1] = 1'b1; req_pc[1] = AW'(12);
    step();
    req_valid[1] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_idle(1, "u1.async_rst");
    check("u1.async_rst.instr", 64'(resp_instr[1]), 64'd0);
    check("u1.async_rst.err",   64'(resp_err[1]),   64'd0);
    #3 rst = 1'b1;
    step();
    chk_idle(1, "u1.after_rst");
    fetch(1, 12, 0, 0);
    fetch(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
